// File: rtl/if_stage.sv
// if_stage: instruction fetch with credit-limited imem requests, a registered fetch FIFO and redirect flush.
// Optional IF_STAGE_MISALIGN_CHECK_EN adds if_misalign_o and blocks fetch after a misaligned redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o
`ifdef IF_STAGE_MISALIGN_CHECK_EN
  ,output logic       if_misalign_o
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_e;
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, rpc;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, tw_q, tw_d, tr_q, tr_d;
  logic [31:0] inst_q [FIFO_DEPTH];
  logic [31:0] inst_d [FIFO_DEPTH];
  logic [31:0] ipc_q [FIFO_DEPTH];
  logic [31:0] ipc_d [FIFO_DEPTH];
  logic [31:0] tag_q [FIFO_DEPTH];
  logic [31:0] tag_d [FIFO_DEPTH];
  logic block, fire, push, pop;
`ifdef IF_STAGE_MISALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign rpc = redirect_pc_i;
  assign block = mis_q;
  assign if_misalign_o = mis_q;
  assign mis_d = redirect_i ? (redirect_pc_i[1:0] != 2'b00) : mis_q;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) mis_q <= 1'b0;
    else mis_q <= mis_d;
`else
  assign rpc = redirect_pc_i & 32'hFFFF_FFFC;
  assign block = 1'b0;
`endif
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) state_q <= BOOT;
    else state_q <= state_d;
  always_comb state_d = (drop_d != '0) ? FLUSH : RUN;
  always_comb begin
    imem_req_valid_o = (state_q != BOOT) & !redirect_i & !block & ((out_q + cnt_q) < DEPTH_C);
    imem_req_addr_o = pc_q;
    if_valid_o = cnt_q != '0;
    if_inst_o = inst_q[rd_q];
    if_pc_o = ipc_q[rd_q];
  end
  // The tag queue is never flushed: its occupancy always equals outstanding, so dropped words pop their stale tags.
  always_comb begin
    fire = imem_req_valid_o & imem_req_ready_i;
    push = imem_rsp_valid_i & (drop_q == '0) & !redirect_i;
    pop = if_valid_o & if_ready_i & !redirect_i;
    pc_d = redirect_i ? rpc : fire ? pc_q + 32'd4 : pc_q;
    out_d = out_q + CW'(fire) - CW'(imem_rsp_valid_i);
    drop_d = redirect_i ? out_d : (imem_rsp_valid_i && drop_q != '0) ? drop_q - CW'(1) : drop_q;
    tw_d = tw_q + AW'(fire);
    tr_d = tr_q + AW'(imem_rsp_valid_i);
    wr_d = redirect_i ? '0 : wr_q + AW'(push);
    rd_d = redirect_i ? '0 : rd_q + AW'(pop);
    cnt_d = redirect_i ? '0 : cnt_q + CW'(push) - CW'(pop);
    tag_d = tag_q;
    inst_d = inst_q;
    ipc_d = ipc_q;
    if (fire) tag_d[tw_q] = pc_q;
    if (push) begin
      inst_d[wr_q] = imem_rsp_data_i;
      ipc_d[wr_q] = tag_q[tr_q];
    end
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      tw_q <= '0;
      tr_q <= '0;
      inst_q <= '{default: '0};
      ipc_q <= '{default: '0};
      tag_q <= '{default: '0};
    end else begin
      pc_q <= pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      tw_q <= tw_d;
      tr_q <= tr_d;
      inst_q <= inst_d;
      ipc_q <= ipc_d;
      tag_q <= tag_d;
    end
  a_no_overflow: assert property (@(posedge clk) disable iff (!arst_n) !(push && cnt_q == DEPTH_C && !pop));
endmodule
